// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: prioritised per-stage stall vector, timed
// branch flush, saturating performance counters and a sticky stall watchdog.
module pipe_stall_ctrl #(
    parameter int unsigned                    STAGES         = 7,
    parameter int unsigned                    NREQ           = 4,
    parameter logic [NREQ*STAGES-1:0]         STALL_MASKS    = {7'b0111101, 7'b0001100,
                                                                7'b0001100, 7'b0000100},
    parameter logic [STAGES-1:0]              RDY_MASK       = 7'b1111100,
    parameter logic [STAGES-1:0]              FLUSH_MASK     = 7'b0000110,
    parameter int unsigned                    BRANCH_BUBBLES = 1,
    parameter int unsigned                    CNT_W          = 32,
    parameter int unsigned                    WDOG_CYCLES    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [NREQ-1:0]   req_i,
    input  logic              branch_i,
    output logic [STAGES-1:0] stall_o,
    output logic [STAGES-1:0] flush_o,
    output logic [CNT_W-1:0]  stall_cycles_o,
    output logic [CNT_W-1:0]  flush_cycles_o,
    output logic              wdog_o
);

    localparam int unsigned       BUB_W  = 4;
    localparam int unsigned       WD_MAX = (WDOG_CYCLES > 2) ? WDOG_CYCLES : 2;
    localparam int unsigned       WD_W   = $clog2(WD_MAX + 1);
    localparam logic [STAGES-1:0] BR_MASK = {{(STAGES-1){1'b0}}, 1'b1} << 2;

    logic             any_req;
    logic             br_accept;
    logic [BUB_W-1:0] bubble_cnt;

    assign any_req   = |req_i;
    assign br_accept = !rst && rdy && !any_req && branch_i;

    // Stall priority: reset, memory not ready, lowest-index request, branch bubble
    always_comb begin
        stall_o = '0;
        if (!rst) begin
            if (!rdy) begin
                stall_o = RDY_MASK;
            end else begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    if (req_i[k]) begin
                        stall_o = STALL_MASKS[k*STAGES +: STAGES];
                    end
                end
                if (!any_req && branch_i) begin
                    stall_o = BR_MASK;
                end
            end
        end
    end

    // Flush bubble counter; frozen while the pipe is stalled so wrong-path stages stay flushed
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (br_accept) begin
            bubble_cnt <= BUB_W'(BRANCH_BUBBLES);
        end else if (rdy && !any_req && bubble_cnt != '0) begin
            bubble_cnt <= bubble_cnt - BUB_W'(1);
        end
    end

    assign flush_o = (bubble_cnt != '0) ? FLUSH_MASK : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_o <= '0;
        end else if (rdy && stall_o != '0 && stall_cycles_o != '1) begin
            stall_cycles_o <= stall_cycles_o + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cycles_o <= '0;
        end else if (flush_o != '0 && flush_cycles_o != '1) begin
            flush_cycles_o <= flush_cycles_o + CNT_W'(1);
        end
    end

    generate
        if (WDOG_CYCLES == 0) begin : g_no_wdog
            assign wdog_o = 1'b0;
        end else begin : g_wdog
            logic [WD_W-1:0] wd_cnt;

            // Counts consecutive ready cycles with a pending request; the flag is sticky
            always_ff @(posedge clk) begin
                if (rst) begin
                    wd_cnt <= '0;
                    wdog_o <= 1'b0;
                end else if (rdy) begin
                    if (any_req) begin
                        if (wd_cnt < WD_W'(WDOG_CYCLES)) begin
                            wd_cnt <= wd_cnt + WD_W'(1);
                        end
                        if (wd_cnt >= WD_W'(WDOG_CYCLES - 1)) begin
                            wdog_o <= 1'b1;
                        end
                    end else begin
                        wd_cnt <= '0;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed vectors push hand-computed
// expectations, a negedge monitor pops and compares them against two DUT configs.
module tb_pipe_stall_ctrl;

    localparam logic [4:0] C_ST = 5'b00001;
    localparam logic [4:0] C_FL = 5'b00010;
    localparam logic [4:0] C_SC = 5'b00100;
    localparam logic [4:0] C_FC = 5'b01000;
    localparam logic [4:0] C_WD = 5'b10000;

    typedef struct {
        logic        sel;
        logic [4:0]  chk;
        logic [6:0]  stall;
        logic [6:0]  flush;
        logic [31:0] sc;
        logic [31:0] fc;
        logic        wd;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [3:0]  req = 4'b1111;
    logic        br  = 1'b1;

    logic [6:0]  st_a, fl_a, st_b, fl_b;
    logic [3:0]  sc_a, fc_a;
    logic [31:0] sc_b, fc_b;
    logic        wd_a, wd_b;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Config A: single bubble, short watchdog, 4-bit counters
    pipe_stall_ctrl #(.BRANCH_BUBBLES(1), .CNT_W(4), .WDOG_CYCLES(8)) u_a (
        .clk(clk), .rst(rst), .rdy(rdy), .req_i(req), .branch_i(br),
        .stall_o(st_a), .flush_o(fl_a), .stall_cycles_o(sc_a),
        .flush_cycles_o(fc_a), .wdog_o(wd_a)
    );

    // Config B: three bubbles, default watchdog and counter width
    pipe_stall_ctrl #(.BRANCH_BUBBLES(3)) u_b (
        .clk(clk), .rst(rst), .rdy(rdy), .req_i(req), .branch_i(br),
        .stall_o(st_b), .flush_o(fl_b), .stall_cycles_o(sc_b),
        .flush_cycles_o(fc_b), .wdog_o(wd_b)
    );

    task automatic cmp(input string name, input string field, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk & C_ST) cmp(e.name, "stall", 32'(e.sel ? st_b : st_a), 32'(e.stall));
            if (e.chk & C_FL) cmp(e.name, "flush", 32'(e.sel ? fl_b : fl_a), 32'(e.flush));
            if (e.chk & C_SC) cmp(e.name, "stall_cycles", e.sel ? sc_b : 32'(sc_a), e.sc);
            if (e.chk & C_FC) cmp(e.name, "flush_cycles", e.sel ? fc_b : 32'(fc_a), e.fc);
            if (e.chk & C_WD) cmp(e.name, "wdog", 32'(e.sel ? wd_b : wd_a), 32'(e.wd));
        end
    end

    task automatic step(input logic r, input logic rd, input logic [3:0] q, input logic b);
        @(posedge clk);
        #1;
        rst = r;
        rdy = rd;
        req = q;
        br  = b;
    endtask

    task automatic push_exp(input logic sel, input logic [4:0] chk, input logic [6:0] stall,
                            input logic [6:0] flush, input logic [31:0] sc,
                            input logic [31:0] fc, input logic wd, input string name);
        exp_t e;
        e.sel = sel; e.chk = chk; e.stall = stall; e.flush = flush;
        e.sc = sc; e.fc = fc; e.wd = wd; e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        // Reset held two cycles with every request and a branch asserted
        step(1, 1, 4'b1111, 1);
        push_exp(0, 5'b11111, 7'b0, 7'b0, 0, 0, 0, "reset_a1");
        step(1, 1, 4'b1111, 1);
        push_exp(0, 5'b11111, 7'b0, 7'b0, 0, 0, 0, "reset_a2");
        push_exp(1, 5'b11111, 7'b0, 7'b0, 0, 0, 0, "reset_b");

        // Priority, then memory not ready
        step(0, 1, 4'b0110, 0);
        push_exp(0, C_ST | C_SC, 7'b0001100, 7'b0, 0, 0, 0, "prio_req1");
        step(0, 0, 4'b0110, 0);
        push_exp(0, C_ST | C_SC, 7'b1111100, 7'b0, 1, 0, 0, "rdy_low");
        step(0, 0, 4'b0110, 0);
        push_exp(0, C_SC, 7'b0, 7'b0, 1, 0, 0, "rdy_low_hold");

        // Accepted branch: one flush cycle
        step(0, 1, 4'b0000, 1);
        push_exp(0, C_ST | C_FL | C_SC, 7'b0000100, 7'b0, 1, 0, 0, "branch");
        step(0, 1, 4'b0000, 0);
        push_exp(0, C_ST | C_FL | C_FC | C_SC, 7'b0, 7'b0000110, 2, 0, 0, "flush_on");
        step(0, 1, 4'b0000, 0);
        push_exp(0, C_FL | C_FC, 7'b0, 7'b0, 0, 1, 0, "flush_off");

        // Branch together with a request is dropped
        step(0, 1, 4'b0100, 1);
        push_exp(0, C_ST | C_SC, 7'b0001100, 7'b0, 2, 0, 0, "req_beats_branch");
        step(0, 1, 4'b0000, 0);
        push_exp(0, C_FL | C_SC, 7'b0, 7'b0, 3, 0, 0, "branch_dropped");

        // Watchdog: 8 consecutive stalled cycles trip it
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 4'b1000, 0);
            if (i == 0) push_exp(0, C_ST | C_SC | C_WD, 7'b0111101, 7'b0, 3, 0, 0, "req3_mask");
            if (i == 7) push_exp(0, C_WD, 7'b0, 7'b0, 0, 0, 0, "wdog_before_8th");
        end
        step(0, 1, 4'b0000, 0);
        push_exp(0, C_WD | C_SC, 7'b0, 7'b0, 11, 0, 1, "wdog_set");
        step(0, 1, 4'b0000, 0);
        push_exp(0, C_WD, 7'b0, 7'b0, 0, 0, 1, "wdog_sticky");
        step(1, 1, 4'b1111, 1);
        push_exp(0, C_ST, 7'b0, 7'b0, 0, 0, 0, "rst_stall_zero");
        step(0, 1, 4'b0000, 0);
        push_exp(0, C_WD | C_SC | C_FC | C_FL, 7'b0, 7'b0, 0, 0, 0, "wdog_cleared");

        // Seven-cycle run, gap, one more: no timeout
        for (int i = 0; i < 7; i++) step(0, 1, 4'b1000, 0);
        step(0, 1, 4'b0000, 0);
        push_exp(0, C_WD, 7'b0, 7'b0, 0, 0, 0, "run7_no_wdog");
        step(0, 1, 4'b1000, 0);
        step(0, 1, 4'b0000, 0);
        push_exp(0, C_WD | C_SC, 7'b0, 7'b0, 8, 0, 0, "gap_no_wdog");

        // Stall counter saturation on a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 4'b0010, 0);
            if (i == 0) push_exp(0, C_ST, 7'b0001100, 7'b0, 0, 0, 0, "req1_mask");
        end
        step(0, 1, 4'b0000, 0);
        push_exp(0, C_SC, 7'b0, 7'b0, 15, 0, 0, "stall_cnt_sat");

        // Reset during a flush
        step(1, 1, 4'b0000, 0);
        step(0, 1, 4'b0000, 1);
        push_exp(0, C_ST, 7'b0000100, 7'b0, 0, 0, 0, "branch_pre_rst");
        step(1, 1, 4'b0000, 0);
        push_exp(0, C_ST | C_FL, 7'b0, 7'b0000110, 0, 0, 0, "flush_at_rst");
        step(0, 1, 4'b0000, 0);
        push_exp(0, C_FL | C_FC, 7'b0, 7'b0, 0, 0, 0, "flush_after_rst");

        // Config B: three bubbles, flush frozen by a 2-cycle stall
        step(1, 1, 4'b0000, 0);
        step(0, 1, 4'b0000, 1);
        push_exp(1, C_ST | C_FL, 7'b0000100, 7'b0, 0, 0, 0, "b_branch");
        step(0, 1, 4'b0000, 0);
        push_exp(1, C_FL | C_FC, 7'b0, 7'b0000110, 0, 0, 0, "b_flush1");
        step(0, 1, 4'b0001, 0);
        push_exp(1, C_ST | C_FL | C_FC, 7'b0000100, 7'b0000110, 0, 1, 0, "b_flush_stall1");
        step(0, 1, 4'b0001, 0);
        push_exp(1, C_FL | C_FC, 7'b0, 7'b0000110, 0, 2, 0, "b_flush_stall2");
        step(0, 1, 4'b0000, 0);
        push_exp(1, C_FL | C_FC, 7'b0, 7'b0000110, 0, 3, 0, "b_flush4");
        step(0, 1, 4'b0000, 0);
        push_exp(1, C_FL | C_FC, 7'b0, 7'b0000110, 0, 4, 0, "b_flush5");
        step(0, 1, 4'b0000, 0);
        push_exp(1, C_FL | C_FC, 7'b0, 7'b0, 0, 5, 0, "b_flush_end");

        // Config B: second branch mid-flush reloads rather than accumulates
        step(0, 1, 4'b0000, 1);
        step(0, 1, 4'b0000, 0);
        step(0, 1, 4'b0000, 1);
        push_exp(1, C_FL, 7'b0, 7'b0000110, 0, 0, 0, "b_reload");
        step(0, 1, 4'b0000, 0);
        step(0, 1, 4'b0000, 0);
        step(0, 1, 4'b0000, 0);
        push_exp(1, C_FL, 7'b0, 7'b0000110, 0, 0, 0, "b_reload_last");
        step(0, 1, 4'b0000, 0);
        push_exp(1, C_FL | C_FC, 7'b0, 7'b0, 0, 10, 0, "b_reload_end");

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
